reset_src: RTL and testbench

RESET_SRC -- requirements
Module: reset_src

---
 rtl/reset_src.sv | 160 ++++++++++++++++
 tb/tb_reset_src.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/reset_src.sv
// Reset source: debounced button, watchdog and software reset requests
// merged into one fixed-length, registered reset pulse with a latched cause.
//
// Ports:
//   i_clk      clock, rising edge
//   i_rst      synchronous active-high reset of this block only
//   i_btn_n    asynchronous external button, active-low
//   i_wdt_en   watchdog enable (level)
//   i_wdt_kick watchdog service (level, sampled every cycle)
//   i_sw_rst   software request, rising edge triggers
//   o_rst_req  registered reset request, PULSE_CYCLES cycles high
//   o_cause    last cause: 0 none, 1 button, 2 watchdog, 3 software
module reset_src #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned WDT_TIMEOUT     = 65535,
    parameter int unsigned PULSE_CYCLES    = 8
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_btn_n,
    input  logic       i_wdt_en,
    input  logic       i_wdt_kick,
    input  logic       i_sw_rst,
    output logic       o_rst_req,
    output logic [1:0] o_cause
);

    typedef enum logic {
        IDLE,
        ASSERT
    } state_t;

    localparam logic [15:0] DB_LAST   = 16'(DEBOUNCE_CYCLES - 1);
    localparam logic [23:0] WDT_LAST  = 24'(WDT_TIMEOUT - 1);
    localparam logic [7:0]  PULSE_LEN = 8'(PULSE_CYCLES);

    logic        sync1_q;
    logic        sync2_q;
    logic        btn_db_q;
    logic [15:0] db_cnt_q;
    logic        btn_evt_q;

    logic [23:0] wdt_cnt_q;
    logic        wdt_evt_q;

    logic        sw_prev_q;
    logic        sw_evt_q;

    state_t      state_q;
    state_t      state_d;
    logic [7:0]  pcnt_q;
    logic [7:0]  pcnt_d;
    logic [1:0]  cause_q;
    logic [1:0]  cause_d;
    logic        rst_req_q;

    // Synchronizer and debouncer; only a press (1->0) raises an event.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            btn_db_q  <= 1'b1;
            db_cnt_q  <= '0;
            btn_evt_q <= 1'b0;
        end else begin
            sync1_q   <= i_btn_n;
            sync2_q   <= sync1_q;
            btn_evt_q <= 1'b0;
            if (sync2_q == btn_db_q) begin
                db_cnt_q <= '0;
            end else if (db_cnt_q == DB_LAST) begin
                btn_db_q  <= sync2_q;
                db_cnt_q  <= '0;
                btn_evt_q <= ~sync2_q;
            end else begin
                db_cnt_q <= db_cnt_q + 16'd1;
            end
        end
    end

    // Watchdog is held cleared while a pulse is in progress.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wdt_cnt_q <= '0;
            wdt_evt_q <= 1'b0;
        end else begin
            wdt_evt_q <= 1'b0;
            if (!i_wdt_en || i_wdt_kick || state_q == ASSERT) begin
                wdt_cnt_q <= '0;
            end else if (wdt_cnt_q == WDT_LAST) begin
                wdt_cnt_q <= '0;
                wdt_evt_q <= 1'b1;
            end else begin
                wdt_cnt_q <= wdt_cnt_q + 24'd1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sw_prev_q <= 1'b0;
            sw_evt_q  <= 1'b0;
        end else begin
            sw_prev_q <= i_sw_rst;
            sw_evt_q  <= i_sw_rst & ~sw_prev_q;
        end
    end

    always_comb begin
        state_d = state_q;
        pcnt_d  = pcnt_q;
        cause_d = cause_q;
        unique case (state_q)
            IDLE: begin
                if (btn_evt_q || wdt_evt_q || sw_evt_q) begin
                    state_d = ASSERT;
                    pcnt_d  = PULSE_LEN;
                    if (btn_evt_q) begin
                        cause_d = 2'd1;
                    end else if (wdt_evt_q) begin
                        cause_d = 2'd2;
                    end else begin
                        cause_d = 2'd3;
                    end
                end
            end
            ASSERT: begin
                // Events here are ignored; the pulse length is fixed.
                if (pcnt_q == 8'd1) begin
                    state_d = IDLE;
                    pcnt_d  = '0;
                end else begin
                    pcnt_d = pcnt_q - 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
                pcnt_d  = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= IDLE;
            pcnt_q    <= '0;
            cause_q   <= 2'd0;
            rst_req_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pcnt_q    <= pcnt_d;
            cause_q   <= cause_d;
            rst_req_q <= (state_d == ASSERT);
        end
    end

    assign o_rst_req = rst_req_q;
    assign o_cause   = cause_q;

endmodule

// File: tb/tb_reset_src.sv
// Randomized and directed bench for reset_src with a queued reference
// model; a negedge monitor compares every cycle's outputs.
module tb_reset_src;

    localparam int DB  = 4;
    localparam int WDT = 10;
    localparam int PL  = 3;

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic       i_btn_n;
    logic       i_wdt_en;
    logic       i_wdt_kick;
    logic       i_sw_rst;
    logic       o_rst_req;
    logic [1:0] o_cause;

    reset_src #(
        .DEBOUNCE_CYCLES(DB),
        .WDT_TIMEOUT    (WDT),
        .PULSE_CYCLES   (PL)
    ) dut (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_btn_n   (i_btn_n),
        .i_wdt_en  (i_wdt_en),
        .i_wdt_kick(i_wdt_kick),
        .i_sw_rst  (i_sw_rst),
        .o_rst_req (o_rst_req),
        .o_cause   (o_cause)
    );

    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_fail   = 0;
    int hi       = 0;

    logic [2:0] exp_q[$];

    // Reference model state
    bit m_s1, m_s2, m_db, m_bevt, m_wevt, m_swp, m_sevt, m_busy;
    int m_run, m_wrun, m_rem, m_cause;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_s1 = 1; m_s2 = 1; m_db = 1; m_run = 0; m_bevt = 0;
        m_wrun = 0; m_wevt = 0; m_swp = 0; m_sevt = 0;
        m_busy = 0; m_rem = 0; m_cause = 0;
    endtask

    task automatic model_step();
        bit nb, nw, ns;
        if (i_rst) begin
            model_reset();
            return;
        end
        nb = 0; nw = 0;
        // Accept a change after DB consecutive differing samples.
        if (m_s2 != m_db) begin
            if (m_run + 1 == DB) begin
                m_db = m_s2; m_run = 0; nb = (m_s2 == 0);
            end else m_run++;
        end else m_run = 0;
        if (i_wdt_en && !i_wdt_kick && !m_busy) begin
            if (m_wrun + 1 == WDT) begin
                m_wrun = 0; nw = 1;
            end else m_wrun++;
        end else m_wrun = 0;
        ns = i_sw_rst && !m_swp;
        m_swp = i_sw_rst;
        if (!m_busy) begin
            if (m_bevt || m_wevt || m_sevt) begin
                m_busy = 1; m_rem = PL;
                m_cause = m_bevt ? 1 : (m_wevt ? 2 : 3);
            end
        end else begin
            m_rem--;
            if (m_rem == 0) m_busy = 0;
        end
        m_bevt = nb; m_wevt = nw; m_sevt = ns;
        m_s2 = m_s1; m_s1 = i_btn_n;
    endtask

    task automatic tick();
        @(posedge i_clk);
        model_step();
        exp_q.push_back({m_busy, 2'(m_cause)});
        #1;
        if (o_rst_req) hi++;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic do_reset();
        i_rst = 1; i_btn_n = 1; i_wdt_en = 0;
        i_wdt_kick = 0; i_sw_rst = 0;
        run(2);
        i_rst = 0;
    endtask

    initial begin : monitor
        logic [2:0] e;
        forever begin
            @(negedge i_clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("rst_req", int'(o_rst_req), int'(e[2]));
                check("cause", int'(o_cause), int'(e[1:0]));
            end
        end
    end

    initial begin : stim
        int hold;
        model_reset();
        do_reset();
        check("reset_req", int'(o_rst_req), 0);
        check("reset_cause", int'(o_cause), 0);

        // Held button press
        do_reset();
        i_btn_n = 0; hi = 0;
        run(20);
        check("btn_pulse_len", hi, PL);
        check("btn_cause", int'(o_cause), 1);
        i_btn_n = 1;
        run(10);

        // Short bounce
        do_reset();
        i_btn_n = 0; hi = 0;
        run(3);
        i_btn_n = 1;
        run(10);
        check("bounce_pulses", hi, 0);
        check("bounce_cause", int'(o_cause), 0);

        // Watchdog timeout
        do_reset();
        i_wdt_en = 1; hi = 0;
        run(20);
        check("wdt_pulse_len", hi, PL);
        check("wdt_cause", int'(o_cause), 2);

        // Kicked every 9 cycles
        do_reset();
        i_wdt_en = 1; hi = 0;
        for (int k = 0; k < 6; k++) begin
            i_wdt_kick = 0; run(8);
            i_wdt_kick = 1; run(1);
        end
        check("wdt_kicked", hi, 0);

        // Software request held high
        do_reset();
        i_sw_rst = 1; hi = 0;
        run(15);
        check("sw_pulse_len", hi, PL);
        check("sw_cause", int'(o_cause), 3);

        // Button and software together, then software during pulse
        do_reset();
        i_btn_n = 0;
        run(5);
        i_sw_rst = 1; hi = 0;
        run(1);
        i_sw_rst = 0;
        run(1);
        i_sw_rst = 1;
        run(12);
        check("prio_pulse_len", hi, PL);
        check("prio_cause", int'(o_cause), 1);

        // Reset in the middle of a pulse
        do_reset();
        i_sw_rst = 1;
        run(2);
        check("mid_pulse_high", int'(o_rst_req), 1);
        i_rst = 1;
        run(1);
        check("mid_rst_req", int'(o_rst_req), 0);
        check("mid_rst_cause", int'(o_cause), 0);
        i_rst = 0; i_sw_rst = 0;
        run(2);
        i_sw_rst = 1; hi = 0;
        run(8);
        check("rearm_pulse_len", hi, PL);
        check("rearm_cause", int'(o_cause), 3);

        // Random traffic
        do_reset();
        hold = 0;
        for (int k = 0; k < 3000; k++) begin
            if (hold == 0) begin
                i_btn_n = ($urandom_range(0, 2) != 0);
                hold = $urandom_range(1, 9);
            end
            hold--;
            if ($urandom_range(0, 30) == 0) i_wdt_en = ~i_wdt_en;
            i_wdt_kick = ($urandom_range(0, 11) == 0);
            i_sw_rst   = ($urandom_range(0, 5) == 0);
            i_rst      = ($urandom_range(0, 299) == 0);
            tick();
        end
        i_rst = 0;

        repeat (3) @(negedge i_clk);
        check("queue_drain", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
